// File: rtl/acc_pkg.sv
// Shared types and constants for the 5-bit accumulator front-end and its add/subtract datapath.
package acc_pkg;

  localparam int ACC_W = 5;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } acc_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } acc_state_t;

  // One-bit full-adder cell; returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    return {(a & b) | (a & cin) | (b & cin), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/add_sub_w.sv
// Combinational WIDTH-bit ripple add/subtract; sub inverts b and doubles as the carry-in.
module add_sub_w
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_W
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic                    sub,
  output logic signed [WIDTH-1:0] sum,
  output logic                    ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   carry;

  assign b_eff    = b ^ {WIDTH{sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    assign {carry[i+1], sum[i]} = full_add(a[i], b_eff[i], carry[i]);
  end

  // Sign-bit overflow: effective operands agree in sign but the result does not.
  // The final carry is intentionally left unused.
  assign ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/five_bit_accumulator_unit.sv
// Accumulator front-end: accepts one command, executes it for one cycle, then holds the result
// until the consumer takes it.
module five_bit_accumulator_unit
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_ovf,
  output logic             sticky_ovf
);

  acc_state_t state, state_nxt;

  acc_op_t                 op_p0;
  logic signed [WIDTH-1:0] data_p0;
  logic signed [WIDTH-1:0] acc_p1;
  logic                    ovf_p1;
  logic                    sticky_p1;

  logic signed [WIDTH-1:0] sum;
  logic                    add_ovf;
  logic                    sub_p0;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_RESP);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Stage p0: command latch, only loaded on an accepted handshake.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      op_p0   <= acc_op_t'(in_op);
      data_p0 <= signed'(in_data);
    end
  end

  assign sub_p0 = (op_p0 == OP_SUB);

  add_sub_w #(.WIDTH(WIDTH)) u_add_sub (
    .a   (acc_p1),
    .b   (data_p0),
    .sub (sub_p0),
    .sum (sum),
    .ovf (add_ovf)
  );

  // Stage p1: architectural accumulator and flags, written only in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p1    <= '0;
      ovf_p1    <= 1'b0;
      sticky_p1 <= 1'b0;
    end else if (state == ST_EXEC) begin
      case (op_p0)
        OP_LOAD: begin
          acc_p1 <= data_p0;
          ovf_p1 <= 1'b0;
        end
        OP_ADD, OP_SUB: begin
          acc_p1    <= sum;
          ovf_p1    <= add_ovf;
          sticky_p1 <= sticky_p1 | add_ovf;
        end
        default: begin
          acc_p1    <= '0;
          ovf_p1    <= 1'b0;
          sticky_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign out_acc    = acc_p1;
  assign out_ovf    = ovf_p1;
  assign sticky_ovf = sticky_p1;

endmodule
